io_prog_loader: RTL and testbench

Sequencer for the serial configuration chain of an I/O bank. It loads a configuration image into the chain from a word-wide host stream by driving the chain's serial input and shift enable. It also reads the chain back non-destructively by recirculating the chain output into its input, returning the contents as a word stream. It sits between the configuration host and the chain's serial input, serial output and shift-enable pins.

---
 rtl/io_prog_loader.sv | 168 ++++++++++++++++
 tb/tb_io_prog_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_prog_loader.sv
// Serial configuration-chain sequencer for an I/O bank: streams host words into
// the chain (LOAD) or recirculates the chain to read it back as words (READ).
module io_prog_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              cmd_load,
  input  logic              cmd_read,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              prog_data,
  input  logic              prog_ret,
  output logic              prog_en,
  output logic              busy,
  output logic              done
);

  localparam int RW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d, bitcnt_nx;
  logic [WORD_W-1:0] sbuf_q, sbuf_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [WORD_W-1:0] col_q, col_d, col_n;
  logic [RW-1:0]     colcnt_q, colcnt_d, cnt_n;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              prog_en_q, prog_en_d;
  logic              prog_data_q, prog_data_d;
  logic              shift, accept;
  int                left_i;

  // A registered prog_en means the chain shifts at the edge that ends this cycle
  assign shift     = prog_en_q;
  assign bitcnt_nx = bitcnt_q + CNT_W'(shift);
  assign accept    = wr_valid & wr_ready;

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      sbuf_q      <= '0;
      rem_q       <= '0;
      col_q       <= '0;
      colcnt_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sbuf_q      <= sbuf_d;
      rem_q       <= rem_d;
      col_q       <= col_d;
      colcnt_q    <= colcnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      prog_en_q   <= prog_en_d;
      prog_data_q <= prog_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_load)      state_d = S_LOAD;
        else if (cmd_read) state_d = S_READ;
      end
      S_LOAD:
        if (int'(bitcnt_nx) == CHAIN_LEN) state_d = S_FINISH;
      S_READ:
        if (int'(bitcnt_q) == CHAIN_LEN && colcnt_q == '0 && rd_valid_q && rd_ready)
          state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bitcnt_d    = bitcnt_q;
    sbuf_d      = sbuf_q;
    rem_d       = rem_q;
    col_d       = col_q;
    colcnt_d    = colcnt_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    prog_en_d   = 1'b0;
    prog_data_d = 1'b0;
    col_n       = col_q;
    cnt_n       = colcnt_q;
    left_i      = CHAIN_LEN - int'(bitcnt_nx);
    case (state_q)
      S_IDLE: begin
        bitcnt_d  = '0;
        sbuf_d    = '0;
        rem_d     = '0;
        col_d     = '0;
        colcnt_d  = '0;
        prog_en_d = cmd_read & ~cmd_load;
      end
      S_LOAD: begin
        bitcnt_d = bitcnt_nx;
        if (accept) begin
          // Final word keeps only the bits the chain still needs
          sbuf_d = wr_data;
          rem_d  = (left_i >= WORD_W) ? RW'(WORD_W) : RW'(left_i);
        end else if (shift) begin
          sbuf_d = sbuf_q >> 1;
          rem_d  = rem_q - RW'(1);
          if (rem_d == '0) sbuf_d = '0;
        end
        prog_en_d   = (rem_d != '0);
        prog_data_d = (rem_d != '0) & sbuf_d[0];
      end
      S_READ: begin
        bitcnt_d   = bitcnt_nx;
        rd_valid_d = rd_valid_q & ~rd_ready;
        if (shift) begin
          col_n = col_q | (WORD_W'(prog_ret) << colcnt_q);
          cnt_n = colcnt_q + RW'(1);
        end
        // The filling bit is forwarded in the same edge so streaming stays gapless
        if ((cnt_n == RW'(WORD_W) || (cnt_n != '0 && int'(bitcnt_nx) == CHAIN_LEN)) &&
            (!rd_valid_q || rd_ready)) begin
          rd_data_d  = col_n;
          rd_valid_d = 1'b1;
          col_d      = '0;
          colcnt_d   = '0;
        end else begin
          col_d    = col_n;
          colcnt_d = cnt_n;
        end
        prog_en_d = (int'(bitcnt_nx) < CHAIN_LEN) && (colcnt_d != RW'(WORD_W));
      end
      default: begin
        rd_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == S_LOAD) || (state_q == S_READ);
    done      = (state_q == S_FINISH);
    prog_en   = prog_en_q;
    prog_data = (state_q == S_READ) ? prog_ret : prog_data_q;
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
    wr_ready  = 1'b0;
    if (state_q == S_LOAD) begin
      if (rem_q == '0)
        wr_ready = int'(bitcnt_q) < CHAIN_LEN;
      else if (rem_q == RW'(1) && prog_en_q)
        wr_ready = (int'(bitcnt_q) + 1) < CHAIN_LEN;
    end
  end

endmodule

// File: tb/tb_io_prog_loader.sv
// Directed bench for io_prog_loader: vector table of load/readback runs against a
// behavioural chain model, plus hand-written abort and command-collision sequences.
module tb_io_prog_loader;

  localparam int L = 20;
  localparam int W = 8;

  logic         prog_clk = 1'b0;
  logic         prog_rst = 1'b1;
  logic         cmd_load = 1'b0, cmd_read = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready = 1'b1;
  logic         prog_data, prog_ret, prog_en, busy, done;

  logic [L-1:0] sr = '0;
  logic         cap [0:1023];
  int sh_tot = 0, acc_tot = 0, done_tot = 0, idle_tot = 0, bad_en = 0, rdv_tot = 0;
  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [2:0][7:0] w;
    int              gap;
    int              stall;
    logic [19:0]     exp_bits;
    int              exp_load_idle;
    logic [2:0][7:0] exp_rd;
    logic            exp_stall;
  } vec_t;

  io_prog_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .prog_rst(prog_rst), .cmd_load(cmd_load), .cmd_read(cmd_read),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .prog_data(prog_data), .prog_ret(prog_ret), .prog_en(prog_en),
    .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: first bit shifted in reaches the serial output after L shifts
  assign prog_ret = sr[0];
  always @(posedge prog_clk) if (prog_en) sr <= {prog_data, sr[L-1:1]};

  always @(negedge prog_clk) begin
    if (prog_en) begin
      if (sh_tot < 1024) cap[sh_tot] = prog_data;
      sh_tot++;
    end
    if (wr_valid && wr_ready) acc_tot++;
    if (done) done_tot++;
    if (busy && !prog_en) idle_tot++;
    if (prog_en && !busy) bad_en++;
    if (rd_valid) rdv_tot++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  task automatic pulse_cmd(input logic ld, input logic rd);
    @(posedge prog_clk); #1;
    cmd_load = ld; cmd_read = rd;
    @(posedge prog_clk); #1;
    cmd_load = 1'b0; cmd_read = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    bit ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge prog_clk);
      if (wr_ready) begin ok = 1; break; end
    end
    if (!ok) timeout(nm);
  endtask

  task automatic feed(input logic [2:0][7:0] w, input int gap);
    for (int i = 0; i < 3; i++) begin
      if (gap == 0) begin
        wr_data = w[i]; wr_valid = 1'b1;
        wait_ready("feed wr_ready");
      end else begin
        wr_valid = 1'b0;
        wait_ready("gap wr_ready");
        repeat (gap) @(posedge prog_clk);
        #1;
        wr_data = w[i]; wr_valid = 1'b1;
        wait_ready("feed wr_ready");
      end
      @(posedge prog_clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 100; c++) begin
      @(negedge prog_clk); #1;
      if (done_tot != d0) break;
    end
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0][7:0] w, input int gap, input logic [19:0] exp_bits,
                         input int exp_idle, input string tag);
    int s0, a0, d0, i0;
    logic [19:0] got;
    s0 = sh_tot; a0 = acc_tot; d0 = done_tot; i0 = idle_tot;
    pulse_cmd(1'b1, 1'b0);
    feed(w, gap);
    wait_done(d0);
    for (int i = 0; i < L; i++) got[i] = cap[s0 + i];
    chk({tag, " load bits"},    32'(got), 32'(exp_bits));
    chk({tag, " load shifts"},  sh_tot - s0, 20);
    chk({tag, " load accepts"}, acc_tot - a0, 3);
    chk({tag, " load idle"},    idle_tot - i0, exp_idle);
    chk({tag, " load done"},    done_tot - d0, 1);
    chk({tag, " chain image"},  32'(sr), 32'(exp_bits));
  endtask

  task automatic do_read(input logic [2:0][7:0] exp_rd, input int stall, input logic exp_stall,
                         input logic [19:0] exp_bits, input string tag);
    int s0, d0, i0, k;
    logic [2:0][7:0] got;
    s0 = sh_tot; d0 = done_tot; i0 = idle_tot; k = 0; got = '0;
    rd_ready = (stall == 0);
    pulse_cmd(1'b0, 1'b1);
    for (int c = 0; c < 400 && k < 3; c++) begin
      @(negedge prog_clk);
      if (c >= stall) rd_ready = 1'b1;
      if (rd_valid && rd_ready) begin got[k] = rd_data; k++; end
    end
    if (k < 3) timeout({tag, " read words"});
    wait_done(d0);
    rd_ready = 1'b1;
    chk({tag, " rd word0"},    32'(got[0]), 32'(exp_rd[0]));
    chk({tag, " rd word1"},    32'(got[1]), 32'(exp_rd[1]));
    chk({tag, " rd word2"},    32'(got[2]), 32'(exp_rd[2]));
    chk({tag, " read shifts"}, sh_tot - s0, 20);
    chk({tag, " read stall"},  32'((idle_tot - i0) > 1), 32'(exp_stall));
    chk({tag, " chain kept"},  32'(sr), 32'(exp_bits));
    chk({tag, " read done"},   done_tot - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int s0, a0, d0, r0;
    vecs[0] = '{w: {8'h0F, 8'h3C, 8'hA5}, gap: 0, stall: 0,  exp_bits: 20'hF3CA5,
                exp_load_idle: 1,  exp_rd: {8'h0F, 8'h3C, 8'hA5}, exp_stall: 1'b0};
    vecs[1] = '{w: {8'h0F, 8'h3C, 8'hA5}, gap: 5, stall: 25, exp_bits: 20'hF3CA5,
                exp_load_idle: 16, exp_rd: {8'h0F, 8'h3C, 8'hA5}, exp_stall: 1'b1};
    vecs[2] = '{w: {8'hF3, 8'h00, 8'hFF}, gap: 2, stall: 5,  exp_bits: 20'h300FF,
                exp_load_idle: 7,  exp_rd: {8'h03, 8'h00, 8'hFF}, exp_stall: 1'b0};
    vecs[3] = '{w: {8'h56, 8'h34, 8'h12}, gap: 0, stall: 25, exp_bits: 20'h63412,
                exp_load_idle: 1,  exp_rd: {8'h06, 8'h34, 8'h12}, exp_stall: 1'b1};

    repeat (3) @(posedge prog_clk);
    #1 prog_rst = 1'b0;
    @(negedge prog_clk);
    chk("reset outputs", 32'({prog_en, prog_data, wr_ready, rd_valid, busy, done, rd_data}), 0);

    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].w, vecs[v].gap, vecs[v].exp_bits, vecs[v].exp_load_idle, $sformatf("v%0d", v));
      do_read(vecs[v].exp_rd, vecs[v].stall, vecs[v].exp_stall, vecs[v].exp_bits, $sformatf("v%0d", v));
    end

    // Both commands together: load must win; a mid-load read request is dropped
    s0 = sh_tot; a0 = acc_tot; d0 = done_tot; r0 = rdv_tot;
    pulse_cmd(1'b1, 1'b1);
    chk("both cmd state", 32'({busy, wr_ready, prog_en}), 32'(3'b110));
    fork
      feed({8'h0F, 8'h3C, 8'hA5}, 0);
      begin
        repeat (6) @(posedge prog_clk);
        #1 cmd_read = 1'b1;
        @(posedge prog_clk);
        #1 cmd_read = 1'b0;
      end
    join
    wait_done(d0);
    chk("both shifts",  sh_tot - s0, 20);
    chk("both accepts", acc_tot - a0, 3);
    chk("both no rd",   rdv_tot - r0, 0);
    chk("both done",    done_tot - d0, 1);
    chk("both image",   32'(sr), 32'h000F3CA5);
    chk("both idle after", 32'({busy, prog_en}), 0);

    // Asynchronous abort after 9 shifts, then a clean restart
    s0 = sh_tot; d0 = done_tot;
    pulse_cmd(1'b1, 1'b0);
    wr_data = 8'hA5; wr_valid = 1'b1;
    wait_ready("abort w0");
    @(posedge prog_clk); #1;
    wr_data = 8'h3C;
    wait_ready("abort w1");
    @(posedge prog_clk); #1;
    wr_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (sh_tot - s0 >= 9) break;
      @(negedge prog_clk); #1;
    end
    @(posedge prog_clk);
    #2 prog_rst = 1'b1;
    #1;
    chk("abort outputs", 32'({prog_en, wr_ready, busy}), 0);
    chk("abort shifts", sh_tot - s0, 9);
    repeat (3) @(posedge prog_clk);
    #1 prog_rst = 1'b0;
    chk("abort no done", done_tot - d0, 0);
    do_load({8'h0F, 8'h3C, 8'hA5}, 0, 20'hF3CA5, 1, "restart");

    chk("prog_en outside busy", bad_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
